// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and sizing constants.
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LAT_CNT_W  = 4;
endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, 2**ADDR_WIDTH x 32, write-enable, registered read (read-before-write).
module dmem_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY to a one-cycle response pulse.
// stall/req_ready come straight from the FSM state; errors suppress the store and zero the data.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);
  localparam int OFS_W = $clog2(WORD_BYTES);
  localparam logic [LAT_CNT_W-1:0] CNT_INIT =
    (LATENCY > 1) ? LAT_CNT_W'(LATENCY - 2) : '0;

  state_t                 state, nstate;
  logic [LAT_CNT_W-1:0]   cnt;
  logic                   lat_write;
  logic [31:0]            lat_addr;
  logic [31:0]            lat_wdata;
  logic                   err_q;
  logic                   load_q;
  logic [31:0]            ram_q;

  logic                   accept;
  logic                   enter_resp;
  logic                   cur_write;
  logic [31:0]            cur_addr;
  logic [31:0]            cur_wdata;
  logic                   cur_err;

  assign accept = req_valid & req_ready;

  // With LATENCY==1 the RAM is accessed on the accept edge itself, so use the live request.
  assign cur_write = (state == IDLE) ? req_write : lat_write;
  assign cur_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign cur_err   = (cur_addr[OFS_W-1:0] != '0) || (cur_addr[31:ADDR_WIDTH+2] != '0);

  assign enter_resp = (nstate == RESP) && (state != RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (cnt == '0) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    stall     = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= CNT_INIT;
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        err_q  <= cur_err;
        load_q <= ~cur_err & ~cur_write;
      end
    end
  end

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .en    (enter_resp & ~cur_err),
    .we    (cur_write),
    .addr  (cur_addr[ADDR_WIDTH+1:2]),
    .wdata (cur_wdata),
    .rdata (ram_q)
  );

  // RAM output register is not reset; qualify it so idle/error/store cycles read as zero.
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & load_q) ? ram_q : 32'h0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: a LATENCY=2 and a LATENCY=1 responder checked against a word-array model.
module tb_data_mem_responder;
  logic        clk;
  logic        rst_n;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        stall     [2];

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] model [2][256];

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .stall(stall[0])
  );

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .stall(stall[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit is_err(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024);
  endfunction

  // One request from an idle responder; checks every cycle until it is idle again.
  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd);
    int lat = lat_of(d);
    bit e = is_err(a);
    logic [31:0] exp_rd = (e || w) ? 32'h0 : model[d][a[9:2]];
    @(negedge clk);
    chk("ready_before_req", {31'b0, req_ready[d]}, 32'd1);
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0; req_addr[d] = $urandom; req_wdata[d] = $urandom; req_write[d] = $urandom;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      chk("stall_inflight", {31'b0, stall[d]}, 32'd1);
      chk("ready_inflight", {31'b0, req_ready[d]}, 32'd0);
      chk("rsp_valid_timing", {31'b0, rsp_valid[d]}, (i == lat) ? 32'd1 : 32'd0);
      if (i == lat) begin
        chk("rsp_err", {31'b0, rsp_err[d]}, {31'b0, e});
        chk("rsp_rdata", rsp_rdata[d], exp_rd);
      end else begin
        chk("rsp_rdata_idle", rsp_rdata[d], 32'h0);
      end
    end
    @(negedge clk);
    chk("stall_after", {31'b0, stall[d]}, 32'd0);
    chk("rsp_valid_after", {31'b0, rsp_valid[d]}, 32'd0);
    chk("rsp_rdata_after", rsp_rdata[d], 32'h0);
    if (w && !e) model[d][a[9:2]] = wd;
  endtask

  initial begin
    int rsp_cnt;
    logic [31:0] got [2];
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", {31'b0, req_ready[d]}, 32'd1);
      chk("reset_stall", {31'b0, stall[d]}, 32'd0);
      chk("reset_rsp_valid", {31'b0, rsp_valid[d]}, 32'd0);
      chk("reset_rdata", rsp_rdata[d], 32'h0);
      chk("reset_err", {31'b0, rsp_err[d]}, 32'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents for word indices 0..15 of the LATENCY=2 responder.
    for (int i = 0; i < 16; i++) txn(0, 1'b1, 32'(i * 4), $urandom);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF);

    // Reset lands during WAIT of a store that must never commit.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h12345678;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, req_ready[0]}, 32'd1);
    chk("midrst_stall", {31'b0, stall[0]}, 32'd0);
    chk("midrst_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    chk("midrst_rdata", rsp_rdata[0], 32'h0);
    chk("midrst_err", {31'b0, rsp_err[0]}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 32'h10, 32'h0);

    // Error cases: misaligned load, out-of-range and misaligned stores must not touch the array.
    txn(0, 1'b0, 32'h13, 32'h0);
    txn(0, 1'b1, 32'h400, 32'hCAFEF00D);
    txn(0, 1'b0, 32'h0, 32'h0);
    txn(0, 1'b1, 32'h11, 32'hBADBAD00);
    txn(0, 1'b0, 32'h10, 32'h0);
    txn(0, 1'b0, 32'h8000_0010, 32'h0);
    txn(0, 1'b0, 32'h3FC, 32'h0 + model[0][255] * 0);

    // Back-to-back loads with req_valid held; responses at cycles LAT and 2*LAT+1.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h4;
    rsp_cnt = 0;
    got[0] = 'x; got[1] = 'x;
    @(posedge clk);
    for (int cyc = 1; cyc <= 2 * (lat_of(0) + 1); cyc++) begin
      @(negedge clk);
      chk("b2b_ready", {31'b0, req_ready[0]}, (cyc % (lat_of(0) + 1) == 0) ? 32'd1 : 32'd0);
      if (rsp_valid[0]) begin
        if (rsp_cnt < 2) got[rsp_cnt] = rsp_rdata[0];
        rsp_cnt++;
        req_addr[0] = 32'h8;
      end
      if (cyc == lat_of(0) + 1) begin
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        cyc++;
        @(negedge clk);
        chk("b2b_second_inflight", {31'b0, stall[0]}, 32'd1);
      end
    end
    req_valid[0] = 1'b0;
    chk("b2b_rsp_count", 32'(rsp_cnt), 32'd2);
    chk("b2b_first_data", got[0], model[0][1]);
    chk("b2b_second_data", got[1], model[0][2]);

    // Randomized mix against the model.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      int kind = $urandom_range(0, 9);
      if (kind < 7)      a = 32'($urandom_range(0, 15) * 4);
      else if (kind < 9) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else               a = 32'h400 + 32'($urandom_range(0, 255) * 4);
      txn(0, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // LATENCY=1 responder at the top word.
    txn(1, 1'b1, 32'h3FC, 32'hA5A55A5A);
    txn(1, 1'b0, 32'h3FC, 32'h0);
    txn(1, 1'b1, 32'h0, 32'h01020304);
    txn(1, 1'b0, 32'h0, 32'h0);
    txn(1, 1'b0, 32'h3FE, 32'h0);
    txn(1, 1'b0, 32'h3FC, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
